// File: rtl/uart_rx_capture_pkg.sv
// uart_rx_capture_pkg: receive FSM state type and default BAUD_DIV / END_CHAR constants
package uart_rx_capture_pkg;
    localparam int         DEF_BAUD_DIV = 16;
    localparam logic [7:0] DEF_END_CHAR = 8'h04;
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_CAPTURE_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } rx_state_e;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO with registered storage.
// Ports: clk_i/rst_i (sync, active-high), push_i/data_i/full_o write side,
// pop_i/data_o/empty_o read side, count_o occupancy. A push while full is
// accepted only when a pop happens in the same cycle. data_o reads 0 when empty.
module uart_rx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [7:0]               data_i,
    output logic                     full_o,
    input  logic                     pop_i,
    output logic [7:0]               data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_pop, do_push;
    assign empty_o = cnt_q == '0;
    assign full_o  = cnt_q == CW'(DEPTH);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = empty_o ? 8'h00 : mem_q[rd_q];
    assign count_o = cnt_q;
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end
endmodule

// File: rtl/uart_rx_capture.sv
// uart_rx_capture: UART (8N1) receiver feeding a byte FIFO, with end-of-simulation detect.
// Ports: CLK, RESET (sync, active-high), RXD serial in; RX_DATA/RX_VALID/RX_READY
// FIFO read handshake, FIFO_COUNT occupancy; FRAME_ERR/OVERRUN one-cycle pulses;
// SIMULATIONEND sticky flag. Macro UART_RX_CAPTURE_PARITY_EN adds an even-parity
// bit after the data bits and a PARITY_ERR pulse output.
module uart_rx_capture
    import uart_rx_capture_pkg::*;
#(
    parameter int         BAUD_DIV   = DEF_BAUD_DIV,
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] END_CHAR   = DEF_END_CHAR
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic                          RXD,
    output logic [7:0]                    RX_DATA,
    output logic                          RX_VALID,
    input  logic                          RX_READY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          FRAME_ERR,
    output logic                          OVERRUN,
`ifdef UART_RX_CAPTURE_PARITY_EN
    output logic                          PARITY_ERR,
`endif
    output logic                          SIMULATIONEND
);
    localparam int            DW        = $clog2(BAUD_DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(BAUD_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF  = DW'(BAUD_DIV / 2 - 1);
    rx_state_e     state_q, state_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          rxd_m_q, rxd_s_q;
    logic          ferr_q, ferr_d;
    logic          ovr_q, end_q;
    logic          push_try, keep, full, empty, pop;
`ifdef UART_RX_CAPTURE_PARITY_EN
    logic          bad_q, bad_d, perr_q, perr_d;
    assign keep       = ~bad_q;
    assign PARITY_ERR = perr_q;
`else
    assign keep = 1'b1;
`endif
    assign pop           = RX_READY & ~empty;
    assign RX_VALID      = ~empty;
    assign FRAME_ERR     = ferr_q;
    assign OVERRUN       = ovr_q;
    assign SIMULATIONEND = end_q;
    always_comb begin
        state_d  = state_q;
        div_d    = div_q + 1'b1;
        bit_d    = bit_q;
        shift_d  = shift_q;
        push_try = 1'b0;
        ferr_d   = 1'b0;
`ifdef UART_RX_CAPTURE_PARITY_EN
        bad_d    = bad_q;
        perr_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                div_d = '0;
`ifdef UART_RX_CAPTURE_PARITY_EN
                bad_d = 1'b0;
`endif
                // IDLE is only entered with the line high, so low here is the start edge
                if (!rxd_s_q) state_d = START;
            end
            START: if (div_q == DIV_HALF) begin
                div_d   = '0;
                bit_d   = '0;
                state_d = rxd_s_q ? IDLE : DATA;
            end
            DATA: if (div_q == DIV_LAST) begin
                div_d   = '0;
                shift_d = {rxd_s_q, shift_q[7:1]};
                bit_d   = bit_q + 3'd1;
`ifdef UART_RX_CAPTURE_PARITY_EN
                if (bit_q == 3'd7) state_d = PARITY;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_RX_CAPTURE_PARITY_EN
            PARITY: if (div_q == DIV_LAST) begin
                div_d   = '0;
                perr_d  = rxd_s_q ^ (^shift_q);
                bad_d   = perr_d;
                state_d = STOP;
            end
`endif
            STOP: if (div_q == DIV_LAST) begin
                div_d    = '0;
                push_try = rxd_s_q & keep;
                ferr_d   = ~rxd_s_q;
                state_d  = rxd_s_q ? IDLE : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                div_d = '0;
                if (rxd_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge CLK) begin
        if (RESET) begin
            rxd_m_q <= 1'b1;
            rxd_s_q <= 1'b1;
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            end_q   <= 1'b0;
`ifdef UART_RX_CAPTURE_PARITY_EN
            bad_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            rxd_m_q <= RXD;
            rxd_s_q <= rxd_m_q;
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            ferr_q  <= ferr_d;
            ovr_q   <= push_try & full & ~pop;
            end_q   <= end_q | (push_try & (shift_q == END_CHAR));
`ifdef UART_RX_CAPTURE_PARITY_EN
            bad_q   <= bad_d;
            perr_q  <= perr_d;
`endif
        end
    end
    uart_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .push_i (push_try),
        .data_i (shift_q),
        .full_o (full),
        .pop_i  (pop),
        .data_o (RX_DATA),
        .empty_o(empty),
        .count_o(FIFO_COUNT)
    );
endmodule

// File: tb/tb_uart_rx_capture.sv
// tb_uart_rx_capture: directed, table-driven bench for uart_rx_capture
module tb_uart_rx_capture;
    localparam int BD = 16;
`ifdef UART_RX_CAPTURE_PARITY_EN
    localparam int PB = 16;
`else
    localparam int PB = 0;
`endif
    logic       CLK = 1'b0;
    logic       RESET, RXD, RX_READY;
    logic [7:0] RX_DATA;
    logic       RX_VALID, FRAME_ERR, OVERRUN, SIMULATIONEND;
    logic [3:0] FIFO_COUNT;
`ifdef UART_RX_CAPTURE_PARITY_EN
    logic       PARITY_ERR;
    int         pe_cnt = 0;
`endif
    int checks = 0, failures = 0;
    int cyc = 0, last_start = 0, rise_cyc = 0;
    int fe_cnt = 0, ov_cnt = 0, fe0, ov0;
    logic vld_prev = 1'b0;
    typedef struct {
        logic [7:0] d;
        logic       stop;
        int         cnt;
        int         fe;
    } vec_t;
    vec_t vec [5];

    uart_rx_capture dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .RXD          (RXD),
        .RX_DATA      (RX_DATA),
        .RX_VALID     (RX_VALID),
        .RX_READY     (RX_READY),
        .FIFO_COUNT   (FIFO_COUNT),
        .FRAME_ERR    (FRAME_ERR),
        .OVERRUN      (OVERRUN),
`ifdef UART_RX_CAPTURE_PARITY_EN
        .PARITY_ERR   (PARITY_ERR),
`endif
        .SIMULATIONEND(SIMULATIONEND)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) begin
        if (FRAME_ERR) fe_cnt++;
        if (OVERRUN) ov_cnt++;
`ifdef UART_RX_CAPTURE_PARITY_EN
        if (PARITY_ERR) pe_cnt++;
`endif
        if (RX_VALID && !vld_prev) rise_cyc = cyc;
        vld_prev = RX_VALID;
    end

    task automatic chk(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", n, a, e);
        end
    endtask

    task automatic rst();
        RESET = 1'b1;
        RXD = 1'b1;
        RX_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b0;
        repeat (4) @(posedge CLK);
    endtask

    // nbits < 8 abandons the frame mid-way through bit nbits-1
    task automatic send(input logic [7:0] d, input logic stop, input int nbits, input logic bad_par);
        @(posedge CLK);
        #1 RXD = 1'b0;
        last_start = cyc;
        for (int i = 0; i < nbits; i++) begin
            repeat (BD) @(posedge CLK);
            #1 RXD = d[i];
        end
        if (nbits < 8) begin
            repeat (BD / 2) @(posedge CLK);
            return;
        end
`ifdef UART_RX_CAPTURE_PARITY_EN
        repeat (BD) @(posedge CLK);
        #1 RXD = (^d) ^ bad_par;
`endif
        repeat (BD) @(posedge CLK);
        #1 RXD = stop;
        repeat (BD) @(posedge CLK);
        #1 RXD = 1'b1;
        repeat (20) @(posedge CLK);
    endtask

    task automatic pop_chk(input logic [7:0] e);
        @(negedge CLK);
        chk($sformatf("pop_valid_%02h", e), RX_VALID, 1);
        chk($sformatf("pop_data_%02h", e), RX_DATA, e);
        RX_READY = 1'b1;
        @(posedge CLK);
        #1 RX_READY = 1'b0;
    endtask

    initial begin
        vec[0] = '{8'h55, 1'b1, 1, 0};
        vec[1] = '{8'hA3, 1'b0, 1, 1};
        vec[2] = '{8'h3C, 1'b1, 2, 0};
        vec[3] = '{8'h00, 1'b1, 3, 0};
        vec[4] = '{8'hFF, 1'b1, 4, 0};
        rst();
        @(negedge CLK);
        chk("rst_valid", RX_VALID, 0);
        chk("rst_data", RX_DATA, 0);
        chk("rst_count", FIFO_COUNT, 0);
        chk("rst_ferr", FRAME_ERR, 0);
        chk("rst_ovr", OVERRUN, 0);
        chk("rst_simend", SIMULATIONEND, 0);

        for (int i = 0; i < 5; i++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            send(vec[i].d, vec[i].stop, 8, 1'b0);
            @(negedge CLK);
            chk($sformatf("vec%0d_count", i), FIFO_COUNT, vec[i].cnt);
            chk($sformatf("vec%0d_ferr", i), fe_cnt - fe0, vec[i].fe);
            chk($sformatf("vec%0d_ovr", i), ov_cnt - ov0, 0);
            if (i == 0) begin
                checks++;
                if (rise_cyc - last_start < 150 + PB || rise_cyc - last_start > 160 + PB) begin
                    failures++;
                    $display("FAIL latency actual=%0d required=%0d..%0d", rise_cyc - last_start, 150 + PB, 160 + PB);
                end
            end
        end
`ifdef UART_RX_CAPTURE_PARITY_EN
        chk("vec_perr", pe_cnt, 0);
`endif
        chk("vec_simend", SIMULATIONEND, 0);
        pop_chk(8'h55);
        pop_chk(8'h3C);
        pop_chk(8'h00);
        pop_chk(8'hFF);

        RX_READY = 1'b1;
        repeat (5) @(posedge CLK);
        @(negedge CLK);
        chk("empty_ready_count", FIFO_COUNT, 0);
        chk("empty_ready_valid", RX_VALID, 0);
        RX_READY = 1'b0;

        fe0 = fe_cnt;
        @(posedge CLK);
        #1 RXD = 1'b0;
        repeat (4) @(posedge CLK);
        #1 RXD = 1'b1;
        repeat (40) @(posedge CLK);
        @(negedge CLK);
        chk("glitch_count", FIFO_COUNT, 0);
        chk("glitch_ferr", fe_cnt - fe0, 0);

        ov0 = ov_cnt;
        for (int b = 1; b <= 8; b++) send(8'(b), 1'b1, 8, 1'b0);
        @(negedge CLK);
        chk("fill_count", FIFO_COUNT, 8);
        chk("fill_ovr", ov_cnt - ov0, 0);
        send(8'h09, 1'b1, 8, 1'b0);
        @(negedge CLK);
        chk("ovr_count", FIFO_COUNT, 8);
        chk("ovr_pulse", ov_cnt - ov0, 1);
        chk("ovr_simend", SIMULATIONEND, 1);

        ov0 = ov_cnt;
        fork
            send(8'h0A, 1'b1, 8, 1'b0);
            begin
                repeat (155 + PB) @(posedge CLK);
                #1 RX_READY = 1'b1;
                @(posedge CLK);
                #1 RX_READY = 1'b0;
            end
        join
        @(negedge CLK);
        chk("pushpop_count", FIFO_COUNT, 8);
        chk("pushpop_ovr", ov_cnt - ov0, 0);
        for (int b = 2; b <= 8; b++) pop_chk(8'(b));
        pop_chk(8'h0A);
        @(negedge CLK);
        chk("drain_count", FIFO_COUNT, 0);

        rst();
        @(negedge CLK);
        chk("end_pre", SIMULATIONEND, 0);
        send(8'h04, 1'b1, 8, 1'b0);
        @(negedge CLK);
        chk("end_set", SIMULATIONEND, 1);
        pop_chk(8'h04);
        @(negedge CLK);
        chk("end_sticky", SIMULATIONEND, 1);
        rst();
        @(negedge CLK);
        chk("end_cleared", SIMULATIONEND, 0);

        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send(8'h5A, 1'b1, 5, 1'b0);
        rst();
        send(8'h7E, 1'b1, 8, 1'b0);
        @(negedge CLK);
        chk("midrst_count", FIFO_COUNT, 1);
        chk("midrst_ferr", fe_cnt - fe0, 0);
        chk("midrst_ovr", ov_cnt - ov0, 0);
        pop_chk(8'h7E);
`ifdef UART_RX_CAPTURE_PARITY_EN
        fe0 = pe_cnt;
        send(8'h7E, 1'b1, 8, 1'b1);
        @(negedge CLK);
        chk("par_pulse", pe_cnt - fe0, 1);
        chk("par_count", FIFO_COUNT, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
